// File: rtl/stack_unit.sv
// Register-based operand stack for the stack-machine datapath.
// It has a registered top-of-stack read port, occupancy decode, and sticky overflow/underflow flags.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic [WIDTH-1:0] din,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             dout_valid_reg, dout_valid_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;

    logic             full_w, empty_w;
    logic             read_req, read_ok, read_fail;
    logic             replace, push_ok, push_rej, pop_ok;
    logic [AW-1:0]    top_idx, wr_idx;
    logic [DEPTH-1:0] wr_en;
    logic [WIDTH-1:0] top_word;

    assign empty_w = (count_reg == '0);
    assign full_w  = (count_reg == DEPTH_C);

    // top_idx is meaningless while empty; every consumer is gated by ~empty_w
    assign top_idx  = AW'(count_reg - CW'(1));
    assign top_word = mem[top_idx];

    always_comb begin
        read_req  = pop | tos;
        read_ok   = read_req & ~empty_w;
        read_fail = read_req & empty_w;
        replace   = push & pop & ~empty_w;
        push_ok   = push & (replace | ~full_w);
        push_rej  = push & ~replace & full_w;
        pop_ok    = pop & ~empty_w;
        wr_idx    = replace ? top_idx : AW'(count_reg);
    end

    always_comb begin
        count_next      = count_reg;
        dout_next       = dout_reg;
        dout_valid_next = 1'b0;
        overflow_next   = overflow_reg & ~err_clr;
        underflow_next  = underflow_reg & ~err_clr;

        // a push that replaces the top leaves the depth unchanged
        if (replace) begin
            count_next = count_reg;
        end else if (push_ok) begin
            count_next = count_reg + CW'(1);
        end else if (pop_ok) begin
            count_next = count_reg - CW'(1);
        end

        if (read_ok) begin
            dout_next       = top_word;
            dout_valid_next = 1'b1;
        end

        if (push_rej) begin
            overflow_next = 1'b1;
        end
        if (read_fail) begin
            underflow_next = 1'b1;
        end
    end

    // storage entries are not reset, so each one only needs its write enable
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign wr_en[gi] = push_ok && (wr_idx == AW'(gi));

            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    mem[gi] <= din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg      <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            count_reg      <= count_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            overflow_reg   <= overflow_next;
            underflow_reg  <= underflow_next;
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign count      = count_reg;
    assign full       = full_w;
    assign empty      = empty_w;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit with hand-computed expectations for each vector.
// Each operation prints one line, and the bench ends with a single summary line.
module tb_stack_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             push, pop, tos, err_clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid, full, empty, overflow, underflow;
    logic [CW-1:0]    count;

    int vectors;
    int miscompares;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .tos        (tos),
        .din        (din),
        .err_clr    (err_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // apply one cycle of strobes, then sample 1ns after the edge
    task automatic op(input logic p, input logic po, input logic t, input logic ec,
                      input logic [WIDTH-1:0] d);
        push = p; pop = po; tos = t; err_clr = ec; din = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0; err_clr = 1'b0;
        $display("op push=%0b pop=%0b tos=%0b clr=%0b din=%02h -> dout=%02h v=%0b cnt=%0d ovf=%0b unf=%0b",
                 p, po, t, ec, d, dout, dout_valid, count, overflow, underflow);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        push = 1'b0; pop = 1'b0; tos = 1'b0; err_clr = 1'b0; din = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_valid", 32'(dout_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);
        @(negedge clk);
        rst = 1'b1;

        // three pushes, then a non-destructive read
        op(1, 0, 0, 0, 8'h11);
        op(1, 0, 0, 0, 8'h22);
        op(1, 0, 0, 0, 8'h33);
        chk("p3_count", 32'(count), 3);
        chk("p3_empty", 32'(empty), 0);
        chk("p3_full", 32'(full), 0);
        chk("p3_valid_idle", 32'(dout_valid), 0);
        op(0, 0, 1, 0, 8'h00);
        chk("tos_dout", 32'(dout), 32'h33);
        chk("tos_valid", 32'(dout_valid), 1);
        chk("tos_count", 32'(count), 3);
        op(0, 0, 0, 0, 8'h00);
        chk("tos_pulse_end", 32'(dout_valid), 0);
        chk("tos_dout_hold", 32'(dout), 32'h33);

        // drain in LIFO order, then underflow
        op(0, 1, 0, 0, 8'h00);
        chk("pop1_dout", 32'(dout), 32'h33);
        chk("pop1_valid", 32'(dout_valid), 1);
        op(0, 1, 0, 0, 8'h00);
        chk("pop2_dout", 32'(dout), 32'h22);
        op(0, 1, 0, 0, 8'h00);
        chk("pop3_dout", 32'(dout), 32'h11);
        chk("pop3_valid", 32'(dout_valid), 1);
        chk("pop3_empty", 32'(empty), 1);
        chk("pop3_count", 32'(count), 0);
        op(0, 1, 0, 0, 8'h00);
        chk("pop4_unf", 32'(underflow), 1);
        chk("pop4_dout", 32'(dout), 32'h11);
        chk("pop4_valid", 32'(dout_valid), 0);
        chk("pop4_count", 32'(count), 0);

        // fill to DEPTH, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            op(1, 0, 0, 0, WIDTH'(i));
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 16);
        chk("fill_ovf", 32'(overflow), 0);
        op(1, 0, 0, 0, 8'hAA);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);
        op(0, 1, 0, 0, 8'h00);
        chk("ovf_pop_dout", 32'(dout), 32'h0F);
        chk("ovf_pop_count", 32'(count), 15);
        op(1, 0, 0, 0, 8'h0F);
        chk("refill_full", 32'(full), 1);

        // err_clr alone clears both sticky flags
        op(0, 0, 0, 1, 8'h00);
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_unf", 32'(underflow), 0);

        // replace at full
        op(1, 1, 0, 0, 8'h5A);
        chk("rep_dout", 32'(dout), 32'h0F);
        chk("rep_valid", 32'(dout_valid), 1);
        chk("rep_count", 32'(count), 16);
        chk("rep_ovf", 32'(overflow), 0);
        op(0, 0, 1, 0, 8'h00);
        chk("rep_tos", 32'(dout), 32'h5A);

        // push+tos at full: read succeeds, push rejected
        op(1, 0, 1, 0, 8'hBB);
        chk("pt_full_dout", 32'(dout), 32'h5A);
        chk("pt_full_ovf", 32'(overflow), 1);
        chk("pt_full_count", 32'(count), 16);

        // pop+tos acts as a pop
        op(0, 1, 1, 0, 8'h00);
        chk("poptos_dout", 32'(dout), 32'h5A);
        chk("poptos_count", 32'(count), 15);
        for (int i = 14; i >= 0; i--) begin
            op(0, 1, 0, 0, 8'h00);
            chk("drain_dout", 32'(dout), 32'(i));
        end
        chk("drain_empty", 32'(empty), 1);

        // err_clr with a fresh underflow: underflow wins, overflow clears
        op(0, 1, 0, 1, 8'h00);
        chk("clrpop_unf", 32'(underflow), 1);
        chk("clrpop_ovf", 32'(overflow), 0);
        chk("clrpop_valid", 32'(dout_valid), 0);
        chk("clrpop_dout", 32'(dout), 32'h00);

        // push+pop on empty: push lands, pop underflows
        op(0, 0, 0, 1, 8'h00);
        chk("clr2_unf", 32'(underflow), 0);
        op(1, 1, 0, 0, 8'h44);
        chk("pp_empty_unf", 32'(underflow), 1);
        chk("pp_empty_count", 32'(count), 1);
        chk("pp_empty_valid", 32'(dout_valid), 0);

        // push+tos on non-empty returns the pre-push top
        op(1, 0, 1, 0, 8'h55);
        chk("pt_dout", 32'(dout), 32'h44);
        chk("pt_valid", 32'(dout_valid), 1);
        chk("pt_count", 32'(count), 2);
        op(0, 1, 0, 0, 8'h00);
        chk("pt_pop1", 32'(dout), 32'h55);
        op(0, 1, 0, 0, 8'h00);
        chk("pt_pop2", 32'(dout), 32'h44);

        // push+tos on empty: underflow and the push still happens
        op(0, 0, 0, 1, 8'h00);
        op(1, 0, 1, 0, 8'h66);
        chk("pt_empty_unf", 32'(underflow), 1);
        chk("pt_empty_count", 32'(count), 1);
        chk("pt_empty_valid", 32'(dout_valid), 0);
        op(0, 1, 0, 0, 8'h00);
        chk("pt_empty_pop", 32'(dout), 32'h66);

        // asynchronous reset between edges with a push pending
        for (int i = 1; i <= 5; i++) begin
            op(1, 0, 0, 0, WIDTH'(i));
        end
        op(1, 0, 0, 0, 8'hCC);
        op(0, 0, 0, 0, 8'h00);
        op(1, 1, 1, 0, 8'hDD);
        chk("tri_dout", 32'(dout), 32'hCC);
        chk("tri_count", 32'(count), 6);
        op(0, 1, 0, 0, 8'h00);
        chk("pre_ar_count", 32'(count), 5);
        push = 1'b1; din = 8'h99;
        #2;
        rst = 1'b0;
        #1;
        chk("ar_count", 32'(count), 0);
        chk("ar_dout", 32'(dout), 0);
        chk("ar_empty", 32'(empty), 1);
        chk("ar_ovf", 32'(overflow), 0);
        chk("ar_unf", 32'(underflow), 1'b0);
        chk("ar_valid", 32'(dout_valid), 0);
        push = 1'b0;
        @(posedge clk);
        #1;
        chk("ar_hold_count", 32'(count), 0);
        @(negedge clk);
        rst = 1'b1;
        op(1, 0, 0, 0, 8'h77);
        chk("post_ar_count", 32'(count), 1);
        op(0, 1, 0, 0, 8'h00);
        chk("post_ar_dout", 32'(dout), 32'h77);
        chk("post_ar_valid", 32'(dout_valid), 1);
        chk("post_ar_empty", 32'(empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
